// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: single owner of the unified instruction/data memory.
// Handshake: a requester holds req and its payload stable until ack; ack is
// combinational and high in exactly the cycle whose closing edge accepts the
// payload. Dropping req before ack is legal and withdraws the request. The
// response is a one-cycle valid strobe two cycles after the ack cycle; err
// qualifies valid, and rdata is meaningful only while valid is high.
module mem_port_arbiter #(
   parameter int WAIT_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_pc,
   output logic        if_ack,
   output logic        if_valid,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [2:0]  d_funct3,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        d_valid,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        mem_sel,
   output logic        mem_MemRead,
   output logic        mem_MemWrite,
   output logic [11:0] mem_addr,
   output logic [2:0]  mem_funct3,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, ACC_ERR} state_t;

   state_t      state, state_nxt;
   logic [3:0]  starve_cnt;
   logic        starve_full;
   logic        grant_i, grant_d;
   logic        i_ok, d_ok, d_align_ok, d_type_ok;
   logic [11:0] addr_l;
   logic        we_l;
   logic [2:0]  f3_l;
   logic [31:0] wdata_l;
   logic        err_is_d;

   assign dbg_state   = state;
   assign starve_full = (starve_cnt == 4'(WAIT_MAX));

   // Request legality: range, alignment and access type.
   always_comb begin
      i_ok = (if_pc[31:8] == 24'h0) && (if_pc[1:0] == 2'b00);
      case (d_funct3[1:0])
         2'b10:   d_align_ok = (d_addr[1:0] == 2'b00);
         2'b01:   d_align_ok = ~d_addr[0];
         default: d_align_ok = 1'b1;
      endcase
      if (d_we) begin
         case (d_funct3)
            3'b000, 3'b001, 3'b010: d_type_ok = 1'b1;
            default:                d_type_ok = 1'b0;
         endcase
      end else begin
         case (d_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: d_type_ok = 1'b1;
            default:                                d_type_ok = 1'b0;
         endcase
      end
      d_ok = (d_addr[31:8] == 24'h000001) && d_align_ok && d_type_ok;
   end

   // Data has priority unless the fetch has already lost WAIT_MAX times in a row.
   always_comb begin
      grant_d = d_req & ~(if_req & starve_full);
      grant_i = if_req & ~grant_d;
   end

   assign if_ack = grant_i;
   assign d_ack  = grant_d;

   // State register and request latches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
         addr_l     <= 12'd0;
         we_l       <= 1'b0;
         f3_l       <= 3'd0;
         wdata_l    <= 32'd0;
         err_is_d   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant_i || !if_req)
            starve_cnt <= 4'd0;
         else if (!starve_full)
            starve_cnt <= starve_cnt + 4'd1;
         if (grant_d) begin
            addr_l   <= {d_addr[7:2], 6'b0};
            we_l     <= d_we;
            f3_l     <= d_funct3;
            wdata_l  <= d_wdata;
            err_is_d <= 1'b1;
         end else if (grant_i) begin
            addr_l   <= {6'b0, if_pc[7:2]};
            err_is_d <= 1'b0;
         end
      end
   end

   // Next state and memory-side outputs; memory is quiet outside ACC_I/ACC_D.
   always_comb begin
      state_nxt    = IDLE;
      mem_sel      = 1'b0;
      mem_MemRead  = 1'b0;
      mem_MemWrite = 1'b0;
      mem_addr     = 12'd0;
      mem_funct3   = 3'd0;
      mem_data_in  = 32'd0;
      if (grant_d)
         state_nxt = d_ok ? ACC_D : ACC_ERR;
      else if (grant_i)
         state_nxt = i_ok ? ACC_I : ACC_ERR;
      case (state)
         ACC_I: begin
            mem_sel  = 1'b1;
            mem_addr = addr_l;
         end
         ACC_D: begin
            mem_MemRead  = ~we_l;
            mem_MemWrite = we_l;
            mem_addr     = addr_l;
            mem_funct3   = f3_l;
            mem_data_in  = wdata_l;
         end
         default: ;
      endcase
   end

   // Registered responses: one strobe per completed access, none after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid <= 1'b0;
         if_err   <= 1'b0;
         if_rdata <= 32'd0;
         d_valid  <= 1'b0;
         d_err    <= 1'b0;
         d_rdata  <= 32'd0;
      end else begin
         if_valid <= 1'b0;
         if_err   <= 1'b0;
         d_valid  <= 1'b0;
         d_err    <= 1'b0;
         case (state)
            ACC_I: begin
               if_valid <= 1'b1;
               if_rdata <= mem_data_out;
            end
            ACC_D: begin
               d_valid <= 1'b1;
               d_rdata <= we_l ? 32'd0 : mem_data_out;
            end
            ACC_ERR: begin
               if (err_is_d) begin
                  d_valid <= 1'b1;
                  d_err   <= 1'b1;
                  d_rdata <= 32'd0;
               end else begin
                  if_valid <= 1'b1;
                  if_err   <= 1'b1;
                  if_rdata <= 32'd0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory stub, request drivers, response and
// memory-port scoreboards, and a grant-rule model.
module tb_mem_port_arbiter;

  localparam int WM = 2;

  logic        clk, rst;
  logic        if_req, if_ack, if_valid, if_err;
  logic [31:0] if_pc, if_rdata;
  logic        d_req, d_we, d_ack, d_valid, d_err;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_sel, mem_MemRead, mem_MemWrite;
  logic [11:0] mem_addr;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_data_in, mem_data_out;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_pc(if_pc), .if_ack(if_ack), .if_valid(if_valid),
    .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_valid(d_valid), .d_err(d_err),
    .d_rdata(d_rdata),
    .mem_sel(mem_sel), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_addr(mem_addr), .mem_funct3(mem_funct3), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int unsigned cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory stub ----------------
  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] m_imem [64];
  logic [31:0] m_dmem [64];

  function automatic logic [31:0] mem_fmt(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] mem_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [2:0] f3);
    case (f3)
      3'b000:  return {old[31:8], wd[7:0]};
      3'b001:  return {old[31:16], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  always_comb begin
    mem_data_out = 32'h0;
    if (mem_sel) mem_data_out = imem[mem_addr[5:0]];
    else if (mem_MemRead) mem_data_out = mem_fmt(dmem[mem_addr[11:6]], mem_funct3);
  end

  always @(posedge clk)
    if (mem_MemWrite)
      dmem[mem_addr[11:6]] <= mem_merge(dmem[mem_addr[11:6]], mem_data_in, mem_funct3);

  // ---------------- scoreboard ----------------
  // response entry: {cycle[31:0], err, rdata[31:0]}
  // access entry:   {cycle[31:0], sel, rd, wr, addr[11:0], funct3, data[31:0]}
  logic [64:0] exp_i_q[$];
  logic [64:0] exp_d_q[$];
  logic [81:0] exp_acc_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference rules for accepted requests.
  function automatic bit pc_legal(input logic [31:0] pc);
    return (pc < 32'd256) && (pc % 4 == 0);
  endfunction

  function automatic bit d_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit type_ok, align_ok;
    if (we) type_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    type_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (f3 == 3'd2)                     align_ok = (a % 4 == 0);
    else if (f3 == 3'd1 || f3 == 3'd5) align_ok = (a % 2 == 0);
    else                                align_ok = 1'b1;
    return type_ok && align_ok && (a >= 32'd256) && (a < 32'd512);
  endfunction

  // Grant-rule model and output monitor, sampled on the falling edge.
  int wait_cnt = 0;
  always @(negedge clk) begin
    logic exp_d, exp_i;
    logic [81:0] a;
    logic [64:0] r;
    if (rst) begin
      wait_cnt = 0;
    end else begin
      exp_d = d_req && !(if_req && wait_cnt == WM);
      exp_i = if_req && !exp_d;
      chk("d_ack", 128'(d_ack), 128'(exp_d));
      chk("if_ack", 128'(if_ack), 128'(exp_i));
      if (if_req && !exp_i) wait_cnt = (wait_cnt == WM) ? WM : wait_cnt + 1;
      else wait_cnt = 0;

      if (exp_acc_q.size() > 0 && exp_acc_q[0][81:50] == cyc) a = exp_acc_q.pop_front();
      else a = {cyc, 50'h0};
      chk("mem_port", 128'({mem_sel, mem_MemRead, mem_MemWrite, mem_addr, mem_funct3, mem_data_in}),
          128'(a[49:0]));

      if (if_valid) begin
        if (exp_i_q.size() == 0) chk("if_valid_unexpected", 128'(if_valid), 128'(0));
        else begin
          r = exp_i_q.pop_front();
          chk("if_resp", 128'({cyc, if_err, if_rdata}), 128'(r));
        end
      end else if (exp_i_q.size() > 0 && exp_i_q[0][64:33] <= cyc) begin
        r = exp_i_q.pop_front();
        chk("if_valid_missing", 128'(if_valid), 128'(1));
      end

      if (d_valid) begin
        if (exp_d_q.size() == 0) chk("d_valid_unexpected", 128'(d_valid), 128'(0));
        else begin
          r = exp_d_q.pop_front();
          chk("d_resp", 128'({cyc, d_err, d_rdata}), 128'(r));
        end
      end else if (exp_d_q.size() > 0 && exp_d_q[0][64:33] <= cyc) begin
        r = exp_d_q.pop_front();
        chk("d_valid_missing", 128'(d_valid), 128'(1));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic fetch(input logic [31:0] pc, input bit can_drop);
    bit got = 0;
    @(posedge clk); #1;
    if_req = 1'b1;
    if_pc  = pc;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (if_ack) begin
        got = 1;
        if (pc_legal(pc)) begin
          exp_i_q.push_back({cyc + 32'd2, 1'b0, m_imem[pc[7:2]]});
          exp_acc_q.push_back({cyc + 32'd1, 3'b100, {6'b0, pc[7:2]}, 3'b0, 32'h0});
        end else begin
          exp_i_q.push_back({cyc + 32'd2, 1'b1, 32'h0});
        end
        break;
      end
      @(posedge clk); #1;
      if (can_drop && $urandom_range(0, 9) == 0) begin
        if_req = 1'b0;
        return;
      end
    end
    chk("if_ack_seen", 128'(got), 128'(1));
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic data(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input bit can_drop);
    bit got = 0;
    logic [5:0] idx;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    idx = a[7:2];
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (d_ack) begin
        got = 1;
        if (!d_legal(we, f3, a)) begin
          exp_d_q.push_back({cyc + 32'd2, 1'b1, 32'h0});
        end else if (we) begin
          m_dmem[idx] = mem_merge(m_dmem[idx], wd, f3);
          exp_d_q.push_back({cyc + 32'd2, 1'b0, 32'h0});
          exp_acc_q.push_back({cyc + 32'd1, 3'b001, {idx, 6'b0}, f3, wd});
        end else begin
          exp_d_q.push_back({cyc + 32'd2, 1'b0, mem_fmt(m_dmem[idx], f3)});
          exp_acc_q.push_back({cyc + 32'd1, 3'b010, {idx, 6'b0}, f3, wd});
        end
        break;
      end
      @(posedge clk); #1;
      if (can_drop && $urandom_range(0, 9) == 0) begin
        d_req = 1'b0;
        return;
      end
    end
    chk("d_ack_seen", 128'(got), 128'(1));
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_i_q.size() + exp_d_q.size() + exp_acc_q.size()) != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("queues_drained", 128'(exp_i_q.size() + exp_d_q.size() + exp_acc_q.size()), 128'(0));
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 9) == 0) pc[31:8] = 24'($urandom_range(1, 255));
    return pc;
  endfunction

  task automatic rand_data();
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    logic [2:0] ld_types [5];
    ld_types = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    we = 1'($urandom_range(0, 1));
    f3 = we ? 3'($urandom_range(0, 2)) : ld_types[$urandom_range(0, 4)];
    if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
    a = {24'h000001, 6'($urandom_range(0, 63)), 2'b00};
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 9) == 0) a[31:8] = 24'($urandom_range(2, 4095));
    data(we, f3, a, $urandom, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] w;
    rst = 1'b1;
    if_req = 0; if_pc = 0;
    d_req = 0; d_we = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom; imem[i] = w; m_imem[i] = w;
      w = $urandom; dmem[i] = w; m_dmem[i] = w;
    end
    imem[1] = 32'h00002083; m_imem[1] = 32'h00002083;
    dmem[0] = 32'd17;       m_dmem[0] = 32'd17;
    dmem[1] = 32'd9;        m_dmem[1] = 32'd9;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 128'({if_ack, if_valid, if_err, if_rdata, d_ack, d_valid, d_err, d_rdata,
                               mem_sel, mem_MemRead, mem_MemWrite, mem_addr, mem_funct3,
                               mem_data_in}), 128'(0));
    rst = 1'b0;

    // Directed cases.
    fetch(32'd4, 1'b0);
    data(1'b0, 3'd2, 32'd256, 32'h0, 1'b0);
    data(1'b0, 3'd1, 32'd260, 32'h0, 1'b0);
    data(1'b1, 3'd0, 32'd268, 32'h12345611, 1'b0);
    data(1'b0, 3'd4, 32'd268, 32'h0, 1'b0);
    data(1'b0, 3'd2, 32'd258, 32'h0, 1'b0);
    data(1'b0, 3'd2, 32'h1000, 32'h0, 1'b0);
    data(1'b1, 3'd2, 32'h1000, 32'hffffffff, 1'b0);
    data(1'b1, 3'd5, 32'd280, 32'hffffffff, 1'b0);
    fetch(32'd2, 1'b0);
    fetch(32'h100, 1'b0);
    drain();

    // Both sides requesting every cycle: grant pattern checked by the monitor.
    fork
      for (int i = 0; i < 4; i++) fetch({24'h0, 6'(i), 2'b00}, 1'b0);
      for (int i = 0; i < 8; i++) data(1'b0, 3'd2, {24'h1, 6'(i), 2'b00}, 32'h0, 1'b0);
    join
    drain();

    // Reset in the middle of a store access.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'd2; d_addr = 32'd272; d_wdata = 32'hdeadbeef;
    @(negedge clk);
    @(posedge clk); #1;
    d_req = 1'b0;
    chk("store_write_active", 128'(mem_MemWrite), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("reset_drops_write", 128'(mem_MemWrite), 128'(0));
    chk("reset_drops_valid", 128'(d_valid), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    chk("store_aborted_word", 128'(dmem[4]), 128'(m_dmem[4]));
    data(1'b0, 3'd2, 32'd272, 32'h0, 1'b0);
    drain();

    // Randomized traffic with occasional withdrawn requests.
    fork
      for (int i = 0; i < 150; i++) fetch(rand_pc(), 1'b1);
      for (int i = 0; i < 150; i++) rand_data();
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
